hyp_dispatch: RTL and testbench
===============================

// Module: hyp_dispatch
// PURPOSE
//  Upstream front-end for the hypotenuse unit. Buffers (a,b) operand pairs in a small FIFO.
//  Issues each pair to the unit with a one-cycle start pulse and waits for its busy to fall.
//  Registers the 9-bit result and presents it on a valid/ready output port.
//  Turns the unit's start/busy protocol into stream handshakes for the core datapath.
// PARAMETERS
//  DEPTH  4  operand FIFO entries; power of two, >=2
//  TAG_W  4  request tag width (used only with HYP_DISPATCH_TAG_EN)
// PORTS
//  clk_i        in   1   clock, single domain
//  rst_ni       in   1   reset, asynchronous assert, active-low
//  in_valid_i   in   1   operand pair valid
//  in_ready_o   out  1   FIFO not full
//  in_a_i       in   8   operand a
//  in_b_i       in   8   operand b
//  hyp_start_o  out  1   start pulse to the hypotenuse unit
//  hyp_a_o      out  8   operand a to the unit, held through the operation
//  hyp_b_o      out  8   operand b to the unit, held through the operation
//  hyp_busy_i   in   1   busy from the unit
//  hyp_c_i      in   9   result from the unit
//  res_valid_o  out  1   result register full
//  res_ready_i  in   1   consumer accepts the result
//  res_c_o      out  9   floor(sqrt(a*a+b*b))
//  fifo_cnt_o   out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (rst_ni=0) takes effect immediately, without waiting for a clock edge.
//  - Outputs: FIFO empty, fifo_cnt_o=0, in_ready_o=1, res_valid_o=0, res_c_o=0,
//    hyp_start_o=0, hyp_a_o/hyp_b_o=0, FSM in IDLE.
//  FIFO:
//  - Push when in_valid_i&&in_ready_o; pop when the FSM leaves IDLE to ISSUE.
//  - Push and pop in the same cycle are both allowed, including when the FIFO is full.
//  - Read/write pointers wrap modulo DEPTH.
//  FSM states:
//  - IDLE: go to ISSUE when FIFO non-empty && !hyp_busy_i. On that edge, latch the head
//    into hyp_a_o/hyp_b_o and pop it.
//  - ISSUE: hyp_start_o=1 for exactly this cycle; next state WAIT_BUSY.
//  - WAIT_BUSY: go to WAIT_DONE when hyp_busy_i=1, which the unit raises 1 cycle after start.
//  - WAIT_DONE: when hyp_busy_i=0, capture hyp_c_i. This happens only if the result register
//    is empty, or is being drained in this same cycle (res_valid_o&&res_ready_i); then go to
//    IDLE. Otherwise go to HOLD.
//  - HOLD: the unit is idle and its result is stable. Capture hyp_c_i once the result
//    register frees, then go to IDLE.
//  Result register:
//  - res_valid_o rises the cycle after capture.
//  - It clears on res_valid_o&&res_ready_i unless a new capture happens in the same cycle.
//  - res_c_o must not change while res_valid_o=1 and res_ready_i=0.
//  Latency, empty system: input push at edge N -> hyp_start_o high in cycle N+1.
//  Results leave in input order; there is no reordering.
//  Reset mid-operation: the hypotenuse unit has no reset input. After release, IDLE waits
//  for hyp_busy_i=0, so a stale operation is never overlapped or captured.
//  Operand widths are fixed at 8 bits; the result is always 9 bits with no truncation.
// CONFIGURATION
//  HYP_DISPATCH_TAG_EN defined:
//  - Adds ports in_tag_i[TAG_W] and res_tag_o[TAG_W].
//  - The tag is stored per FIFO entry and registered alongside res_c_o.
//  - Reset value of res_tag_o is 0.
//  HYP_DISPATCH_TAG_EN undefined: no tag ports and no tag storage.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/ISSUE/WAIT_BUSY/WAIT_DONE/HOLD, 3 bits),
//  the operand width 8 and the result width 9.
//  One sub-module: hyp_dispatch_fifo, a synchronous DEPTH-entry FIFO with count output;
//  the FSM and result register stay in the top module.
// TESTING
//  - (3,4) pushed, res_ready_i=1 -> one hyp_start_o pulse; res_c_o=5, res_valid_o for 1 cycle.
//  - Back-to-back pushes (5,12),(255,255),(0,0), consumer always ready -> 13, 360, 0 in
//    order; exactly 3 start pulses.
//  - DEPTH+1 pushes while the unit is busy -> in_ready_o=0 at full. With a push and a pop in
//    the same cycle, fifo_cnt_o stays at DEPTH.
//  - res_ready_i=0 for 50 cycles with two pairs queued (6,8),(8,15):
//    - res_c_o holds 10; the FSM sits in HOLD with result 17 pending; no third start pulse.
//    - On release: 10 then 17.
//  - rst_ni low during WAIT_DONE while the model keeps busy high for 20 cycles -> outputs at
//    reset values; no start until busy drops; the next pair (9,12) gives 15.
//  - HYP_DISPATCH_TAG_EN: tags 0xA,0x3 with (3,4),(5,12) -> res_tag_o 0xA with 5,
//    then 0x3 with 13.

Source files
------------

// File: rtl/hyp_dispatch_pkg.sv
// Shared types for the hypotenuse dispatcher: FSM encoding and datapath widths.
package hyp_dispatch_pkg;

   localparam int OP_W  = 8;
   localparam int RES_W = 9;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_HOLD      = 3'd4
   } state_t;

endpackage

// File: rtl/hyp_dispatch_if.sv
// Stream-side and unit-side signals of hyp_dispatch; slave is the dispatcher, master its environment.
// Tag signals exist only when HYP_DISPATCH_TAG_EN is defined.
interface hyp_dispatch_if import hyp_dispatch_pkg::*; #(
   parameter int DEPTH = 4
`ifdef HYP_DISPATCH_TAG_EN
   , parameter int TAG_W = 4
`endif
);
   logic                     in_valid_i;
   logic                     in_ready_o;
   logic [OP_W-1:0]          in_a_i;
   logic [OP_W-1:0]          in_b_i;
   logic                     hyp_start_o;
   logic [OP_W-1:0]          hyp_a_o;
   logic [OP_W-1:0]          hyp_b_o;
   logic                     hyp_busy_i;
   logic [RES_W-1:0]         hyp_c_i;
   logic                     res_valid_o;
   logic                     res_ready_i;
   logic [RES_W-1:0]         res_c_o;
   logic [$clog2(DEPTH):0]   fifo_cnt_o;
`ifdef HYP_DISPATCH_TAG_EN
   logic [TAG_W-1:0]         in_tag_i;
   logic [TAG_W-1:0]         res_tag_o;

   modport slave (
      input  in_valid_i, in_a_i, in_b_i, hyp_busy_i, hyp_c_i, res_ready_i, in_tag_i,
      output in_ready_o, hyp_start_o, hyp_a_o, hyp_b_o, res_valid_o, res_c_o, fifo_cnt_o, res_tag_o
   );
   modport master (
      output in_valid_i, in_a_i, in_b_i, hyp_busy_i, hyp_c_i, res_ready_i, in_tag_i,
      input  in_ready_o, hyp_start_o, hyp_a_o, hyp_b_o, res_valid_o, res_c_o, fifo_cnt_o, res_tag_o
   );
`else
   modport slave (
      input  in_valid_i, in_a_i, in_b_i, hyp_busy_i, hyp_c_i, res_ready_i,
      output in_ready_o, hyp_start_o, hyp_a_o, hyp_b_o, res_valid_o, res_c_o, fifo_cnt_o
   );
   modport master (
      output in_valid_i, in_a_i, in_b_i, hyp_busy_i, hyp_c_i, res_ready_i,
      input  in_ready_o, hyp_start_o, hyp_a_o, hyp_b_o, res_valid_o, res_c_o, fifo_cnt_o
   );
`endif
endinterface

// File: rtl/hyp_dispatch_fifo.sv
// Synchronous DEPTH-entry FIFO with occupancy count; head is visible combinationally.
// Caller gates push/pop; a push while full is legal only together with a pop.
module hyp_dispatch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   i_push,
   input  logic [W-1:0]           i_dat,
   input  logic                   i_pop,
   output logic [W-1:0]           o_dat,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_cnt;

   always_ff @(posedge clk_i) begin
      if (i_push) r_mem[r_wptr] <= i_dat;
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + PTR_ONE;
         if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + CNT_ONE;
            2'b01:   r_cnt <= r_cnt - CNT_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_dat   = r_mem[r_rptr];
   assign o_full  = (r_cnt == CNT_FULL);
   assign o_empty = (r_cnt == '0);
   assign o_cnt   = r_cnt;

endmodule

// File: rtl/hyp_dispatch.sv
// Stream front-end for the hypotenuse unit: FIFO -> start/busy issue -> valid/ready result register.
// Push-to-start 1 cycle; in_ready falls only when full with no pop; HYP_DISPATCH_TAG_EN adds tags.
module hyp_dispatch import hyp_dispatch_pkg::*; #(
   parameter int DEPTH = 4
`ifdef HYP_DISPATCH_TAG_EN
   , parameter int TAG_W = 4
`endif
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   hyp_dispatch_if.slave bus
);
`ifdef HYP_DISPATCH_TAG_EN
   localparam int ENTRY_W = 2*OP_W + TAG_W;
`else
   localparam int ENTRY_W = 2*OP_W;
`endif

   state_t           r_state;
   state_t           w_next;
   logic             w_pop;
   logic             w_cap;
   logic             w_push;
   logic             w_drain;
   logic             w_full;
   logic             w_empty;
   logic [ENTRY_W-1:0] w_head;
   logic [ENTRY_W-1:0] w_push_dat;
   logic [OP_W-1:0]  r_a;
   logic [OP_W-1:0]  r_b;
   logic [RES_W-1:0] r_res_c;
   logic             r_res_vld;

`ifdef HYP_DISPATCH_TAG_EN
   logic [TAG_W-1:0] r_tag;
   logic [TAG_W-1:0] r_res_tag;
   assign w_push_dat = {bus.in_tag_i, bus.in_a_i, bus.in_b_i};
`else
   assign w_push_dat = {bus.in_a_i, bus.in_b_i};
`endif

   assign w_drain        = r_res_vld && bus.res_ready_i;
   assign bus.in_ready_o = !w_full || w_pop;
   assign w_push         = bus.in_valid_i && bus.in_ready_o;

   hyp_dispatch_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_push),
      .i_dat   (w_push_dat),
      .i_pop   (w_pop),
      .o_dat   (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_cnt   (bus.fifo_cnt_o)
   );

   // IDLE also waits on busy so an operation left running across reset is never overlapped.
   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      w_cap  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && !bus.hyp_busy_i) begin
               w_next = S_ISSUE;
               w_pop  = 1'b1;
            end
         end
         S_ISSUE:     w_next = S_WAIT_BUSY;
         S_WAIT_BUSY: if (bus.hyp_busy_i) w_next = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (!bus.hyp_busy_i) begin
               if (!r_res_vld || w_drain) begin
                  w_cap  = 1'b1;
                  w_next = S_IDLE;
               end else begin
                  w_next = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!r_res_vld || w_drain) begin
               w_cap  = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_res_c   <= '0;
         r_res_vld <= 1'b0;
`ifdef HYP_DISPATCH_TAG_EN
         r_tag     <= '0;
         r_res_tag <= '0;
`endif
      end else begin
         r_state <= w_next;
         if (w_pop) begin
            r_a <= w_head[2*OP_W-1:OP_W];
            r_b <= w_head[OP_W-1:0];
`ifdef HYP_DISPATCH_TAG_EN
            r_tag <= w_head[ENTRY_W-1:2*OP_W];
`endif
         end
         // A capture in the drain cycle overrides the clear, so back-to-back results stay valid.
         if (w_cap) begin
            r_res_c   <= bus.hyp_c_i;
            r_res_vld <= 1'b1;
`ifdef HYP_DISPATCH_TAG_EN
            r_res_tag <= r_tag;
`endif
         end else if (w_drain) begin
            r_res_vld <= 1'b0;
         end
      end
   end

   assign bus.hyp_start_o = (r_state == S_ISSUE);
   assign bus.hyp_a_o     = r_a;
   assign bus.hyp_b_o     = r_b;
   assign bus.res_valid_o = r_res_vld;
   assign bus.res_c_o     = r_res_c;
`ifdef HYP_DISPATCH_TAG_EN
   assign bus.res_tag_o   = r_res_tag;
`endif

endmodule

// File: tb/tb_hyp_dispatch.sv
// Scoreboarded bench for hyp_dispatch with a behavioural hypotenuse unit driving busy/result.
module tb_hyp_dispatch;
   import hyp_dispatch_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      int c;
      int tag;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic m_busy = 1'b0;
   logic stale  = 1'b0;
   int   lat    = 3;
   int   errors = 0;
   int   checks = 0;
   int   starts = 0;
   int   vcnt   = 0;
   exp_t exp_q[$];

`ifdef HYP_DISPATCH_TAG_EN
   hyp_dispatch_if #(.DEPTH(DEPTH), .TAG_W(4)) bus();
   hyp_dispatch #(.DEPTH(DEPTH), .TAG_W(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
`else
   hyp_dispatch_if #(.DEPTH(DEPTH)) bus();
   hyp_dispatch #(.DEPTH(DEPTH)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
`endif

   always #5 clk = ~clk;
   assign bus.hyp_busy_i = m_busy | stale;

   function automatic int isqrt(input int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Behavioural unit: busy one cycle after start, result valid when busy falls.
   initial begin : unit_model
      int ma, mb;
      bus.hyp_c_i = '0;
      forever begin
         @(negedge clk);
         if (bus.hyp_start_o) begin
            ma = int'(bus.hyp_a_o);
            mb = int'(bus.hyp_b_o);
            @(posedge clk);
            #1 m_busy = 1'b1;
            repeat (lat) @(posedge clk);
            #1 bus.hyp_c_i = 9'(isqrt(ma * ma + mb * mb));
            m_busy = 1'b0;
         end
      end
   end

   initial begin : pulse_counter
      forever begin
         @(negedge clk);
         if (bus.hyp_start_o) starts++;
         if (bus.res_valid_o) vcnt++;
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.res_valid_o && bus.res_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got c=%0d, none expected", bus.res_c_o);
            end else begin
               e = exp_q.pop_front();
               chk("res_c", 32'(bus.res_c_o), e.c);
`ifdef HYP_DISPATCH_TAG_EN
               chk("res_tag", 32'(bus.res_tag_o), e.tag);
`endif
            end
         end
      end
   end

   // Called #1 after a clock edge; returns #1 after the accepting edge.
   task automatic push(input int a, input int b, input int tag, input int c);
      int n = 0;
      bus.in_valid_i = 1'b1;
      bus.in_a_i     = 8'(a);
      bus.in_b_i     = 8'(b);
`ifdef HYP_DISPATCH_TAG_EN
      bus.in_tag_i   = 4'(tag);
`endif
      @(negedge clk);
      while (!bus.in_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready_o) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: in_ready stayed 0, required 1 for (%0d,%0d)", a, b);
         bus.in_valid_i = 1'b0;
      end else begin
         @(posedge clk);
         #1 bus.in_valid_i = 1'b0;
         exp_q.push_back('{c: c, tag: tag});
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int s;
      int n;
      bus.in_valid_i  = 1'b0;
      bus.in_a_i      = '0;
      bus.in_b_i      = '0;
      bus.res_ready_i = 1'b1;
`ifdef HYP_DISPATCH_TAG_EN
      bus.in_tag_i    = '0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_fifo_cnt", 32'(bus.fifo_cnt_o), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
      chk("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
      chk("rst_res_c", 32'(bus.res_c_o), 32'd0);
      chk("rst_start", 32'(bus.hyp_start_o), 32'd0);
      chk("rst_hyp_a", 32'(bus.hyp_a_o), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single pair
      s = starts;
      vcnt = 0;
      push(3, 4, 'hA, 5);
      wait_drain("t1_drain");
      chk("t1_starts", 32'(starts - s), 32'd1);
      chk("t1_valid_cycles", 32'(vcnt), 32'd1);

      // Back-to-back pairs
      s = starts;
      push(5, 12, 'h3, 13);
      push(255, 255, 0, 360);
      push(0, 0, 0, 0);
      wait_drain("t2_drain");
      chk("t2_starts", 32'(starts - s), 32'd3);

      // Fill the FIFO while the unit is busy
      lat = 12;
      push(3, 4, 1, 5);
      n = 0;
      while (!bus.hyp_busy_i && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t3_busy_seen", 32'(bus.hyp_busy_i), 32'd1);
      @(posedge clk);
      #1;
      push(6, 8, 2, 10);
      push(5, 12, 3, 13);
      push(8, 15, 4, 17);
      push(9, 12, 5, 15);
      @(negedge clk);
      chk("t3_full_cnt", 32'(bus.fifo_cnt_o), 32'(DEPTH));
      chk("t3_full_ready", 32'(bus.in_ready_o), 32'd0);
      @(posedge clk);
      #1 bus.in_valid_i = 1'b1;
      bus.in_a_i = 8'd0;
      bus.in_b_i = 8'd0;
`ifdef HYP_DISPATCH_TAG_EN
      bus.in_tag_i = 4'd6;
`endif
      n = 0;
      @(negedge clk);
      while (!bus.in_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t3_ready_on_pop", 32'(bus.in_ready_o), 32'd1);
      chk("t3_cnt_before", 32'(bus.fifo_cnt_o), 32'(DEPTH));
      @(posedge clk);
      #1 bus.in_valid_i = 1'b0;
      exp_q.push_back('{c: 0, tag: 6});
      chk("t3_cnt_push_pop", 32'(bus.fifo_cnt_o), 32'(DEPTH));
      wait_drain("t3_drain");
      lat = 3;

      // Consumer stalled for 50 cycles
      bus.res_ready_i = 1'b0;
      s = starts;
      push(6, 8, 7, 10);
      push(8, 15, 8, 17);
      repeat (50) begin
         @(negedge clk);
         if (bus.res_valid_o) chk("t4_hold_c", 32'(bus.res_c_o), 32'd10);
      end
      chk("t4_valid", 32'(bus.res_valid_o), 32'd1);
      chk("t4_state_hold", 32'(dut.r_state), 32'(S_HOLD));
      chk("t4_pending_c", 32'(bus.hyp_c_i), 32'd17);
      chk("t4_starts", 32'(starts - s), 32'd2);
      @(posedge clk);
      #1 bus.res_ready_i = 1'b1;
      wait_drain("t4_drain");

      // Reset during WAIT_DONE with the unit still busy
      lat = 8;
      push(3, 4, 9, 5);
      n = 0;
      while (dut.r_state != S_WAIT_DONE && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t5_in_wait_done", 32'(dut.r_state), 32'(S_WAIT_DONE));
      rst_n = 1'b0;
      stale = 1'b1;
      exp_q.delete();
      #1;
      chk("t5_rst_fifo_cnt", 32'(bus.fifo_cnt_o), 32'd0);
      chk("t5_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
      chk("t5_rst_res_valid", 32'(bus.res_valid_o), 32'd0);
      chk("t5_rst_res_c", 32'(bus.res_c_o), 32'd0);
      chk("t5_rst_start", 32'(bus.hyp_start_o), 32'd0);
      chk("t5_rst_hyp_a", 32'(bus.hyp_a_o), 32'd0);
      chk("t5_rst_hyp_b", 32'(bus.hyp_b_o), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      s = starts;
      push(9, 12, 'hC, 15);
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("t5_no_start_while_busy", 32'(starts - s), 32'd0);
      chk("t5_queued", 32'(bus.fifo_cnt_o), 32'd1);
      @(posedge clk);
      #1 stale = 1'b0;
      wait_drain("t5_drain");
      chk("t5_starts", 32'(starts - s), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
